// File: rtl/matmul_round_pkg.sv
// rtl/matmul_round_pkg.sv - shared widths and helpers for the matmul rounding arbiter
package matmul_round_pkg;

    localparam int DEFAULT_WIDTH_PROD         = 8;
    localparam int DEFAULT_WIDTH_PROD_ROUNDED = 4;
    localparam int SAT_COUNT_W                = 16;

    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/round_sat_unit.sv
// rtl/round_sat_unit.sv - combinational round-half-up of a signed product with symmetric clamp
// ROUND_SAT_EN selects clamping; without it results wrap modulo 2^WR and o_clamped is 0.
module round_sat_unit
    import matmul_round_pkg::*;
#(
    parameter int WIDTH_PROD         = DEFAULT_WIDTH_PROD,
    parameter int WIDTH_PROD_ROUNDED = DEFAULT_WIDTH_PROD_ROUNDED
) (
    input  logic [WIDTH_PROD-1:0]         i_prod,
    output logic [WIDTH_PROD_ROUNDED-1:0] o_rounded,
    output logic                          o_clamped
);

    localparam int WP = WIDTH_PROD;
    localparam int WR = WIDTH_PROD_ROUNDED;

    logic [WR-1:0] w_field;
    logic          w_guard;
    logic [WR-1:0] w_sum;
    logic          w_unused_prod;

    // The top bit is a redundant sign copy; the field starts one bit below it.
    assign w_field       = i_prod[WP-2 -: WR];
    assign w_guard       = i_prod[WP-2-WR];
    assign w_sum         = w_field + {{(WR-1){1'b0}}, w_guard};
    assign w_unused_prod = ^i_prod;

`ifdef ROUND_SAT_EN
    localparam logic [WR-1:0] MAX_VAL = {1'b0, {(WR-1){1'b1}}};
    localparam logic [WR-1:0] MIN_VAL = {1'b1, {(WR-1){1'b0}}};

    logic w_sign;
    logic w_is_max;
    logic w_is_min;

    assign w_sign   = i_prod[WP-1];
    assign w_is_max = !w_sign && (w_field == MAX_VAL);
    // Most negative code is never produced so the output range stays symmetric.
    assign w_is_min = w_sign && (w_field == MIN_VAL);

    assign o_clamped = w_is_max || w_is_min;
    assign o_rounded = w_is_max ? MAX_VAL :
                       w_is_min ? (MIN_VAL + {{(WR-1){1'b0}}, 1'b1}) :
                       w_sum;
`else
    assign o_clamped = 1'b0;
    assign o_rounded = w_sum;
`endif

endmodule

// File: rtl/matmul_round_arbiter.sv
// rtl/matmul_round_arbiter.sv - round-robin lane grant into a shared rounder with one-entry output stage
// Clamp behaviour and sat_count depend on ROUND_SAT_EN inside round_sat_unit.
module matmul_round_arbiter
    import matmul_round_pkg::*;
#(
    parameter int  N_REQ              = 4,
    parameter int  WIDTH_PROD         = DEFAULT_WIDTH_PROD,
    parameter int  WIDTH_PROD_ROUNDED = DEFAULT_WIDTH_PROD_ROUNDED,
    localparam int ID_W               = id_w(N_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_REQ-1:0]              i_req_valid,
    input  logic [N_REQ*WIDTH_PROD-1:0]   i_req_prod,
    output logic [N_REQ-1:0]              o_req_ready,
    output logic                          o_res_valid,
    output logic [WIDTH_PROD_ROUNDED-1:0] o_res_data,
    output logic [ID_W-1:0]               o_res_id,
    input  logic                          i_res_ready,
    output logic [SAT_COUNT_W-1:0]        o_sat_count
);

    logic                          r_res_valid;
    logic [WIDTH_PROD_ROUNDED-1:0] r_res_data;
    logic [ID_W-1:0]               r_res_id;
    logic [ID_W-1:0]               r_rr;
    logic [SAT_COUNT_W-1:0]        r_sat_count;

    logic                          w_load;
    logic                          w_found;
    logic                          w_grant;
    logic [ID_W-1:0]               w_grant_idx;
    logic [ID_W-1:0]               w_cand;
    logic [ID_W-1:0]               w_rr_next;
    logic [WIDTH_PROD-1:0]         w_sel_prod;
    logic [WIDTH_PROD_ROUNDED-1:0] w_rounded;
    logic                          w_clamped;

    assign w_load = !r_res_valid || i_res_ready;

    // First requesting lane at or after the pointer, wrapping past N_REQ-1.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = ID_W'((int'(r_rr) + k) % N_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_grant     = w_found && w_load && !i_rst;
    assign o_req_ready = w_grant ? (N_REQ'(1) << w_grant_idx) : '0;
    assign w_sel_prod  = i_req_prod[w_grant_idx*WIDTH_PROD +: WIDTH_PROD];
    assign w_rr_next   = (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : (w_grant_idx + 1'b1);

    round_sat_unit #(
        .WIDTH_PROD         (WIDTH_PROD),
        .WIDTH_PROD_ROUNDED (WIDTH_PROD_ROUNDED)
    ) u_round (
        .i_prod    (w_sel_prod),
        .o_rounded (w_rounded),
        .o_clamped (w_clamped)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_rr        <= '0;
            r_sat_count <= '0;
        end else if (w_grant) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_rounded;
            r_res_id    <= w_grant_idx;
            r_rr        <= w_rr_next;
            if (w_clamped && (r_sat_count != {SAT_COUNT_W{1'b1}})) begin
                r_sat_count <= r_sat_count + 1'b1;
            end
        end else if (i_res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_id    = r_res_id;
    assign o_sat_count = r_sat_count;

endmodule

// File: tb/tb_matmul_round_arbiter.sv
// tb/tb_matmul_round_arbiter.sv - directed and random checks of matmul_round_arbiter against a queue-free arithmetic model
module tb_matmul_round_arbiter;

    localparam int N   = 4;
    localparam int WP  = 8;
    localparam int WR  = 4;
    localparam int IDW = 2;
    localparam int SH  = WP - 1 - WR;
    localparam int M   = 1 << WR;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*WP-1:0] req_prod;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic [WR-1:0]  res_data;
    logic [IDW-1:0] res_id;
    logic           res_ready;
    logic [15:0]    sat_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    matmul_round_arbiter #(
        .N_REQ              (N),
        .WIDTH_PROD         (WP),
        .WIDTH_PROD_ROUNDED (WR)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_prod  (req_prod),
        .o_req_ready (req_ready),
        .o_res_valid (res_valid),
        .o_res_data  (res_data),
        .o_res_id    (res_id),
        .i_res_ready (res_ready),
        .o_sat_count (sat_count)
    );

    bit           lv[N];
    logic [WP-1:0] lp[N];
    bit           m_valid;
    int           m_data, m_id, m_rr, m_sat;
    logic [N-1:0] exp_ready;
    logic [N-1:0] last_dut_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Floor-divide the signed product, round half up, then apply the clamp rules.
    function automatic void model_round(input logic [WP-1:0] p, output int r, output bit clamp);
        int v, q, g, f;
        v = int'($signed(p));
        q = v / (1 << SH);
        if (q * (1 << SH) > v) q--;
        g = ((v - q * (1 << SH)) >= (1 << (SH - 1))) ? 1 : 0;
        f = q & (M - 1);
        clamp = 1'b0;
        r = (q + g) & (M - 1);
`ifdef ROUND_SAT_EN
        if (v >= 0 && f == M / 2 - 1) begin
            r = f;
            clamp = 1'b1;
        end else if (v < 0 && f == M / 2) begin
            r = M / 2 + 1;
            clamp = 1'b1;
        end
`endif
    endfunction

    task automatic tick();
        int  g, r, idx;
        bit  c, load;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = lv[i];
            req_prod[i*WP +: WP]  = lp[i];
        end
        #1;
        g = -1;
        if (!rst) begin
            load = !m_valid || res_ready;
            if (load) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (g < 0 && lv[idx]) g = idx;
                end
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        last_dut_ready = req_ready;
        check_eq("req_ready", req_ready, exp_ready);
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = 0; m_id = 0; m_rr = 0; m_sat = 0;
        end else if (g >= 0) begin
            model_round(lp[g], r, c);
            m_valid = 1'b1;
            m_data  = r;
            m_id    = g;
            m_rr    = (g + 1) % N;
            if (c && m_sat < 65535) m_sat++;
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_eq("res_valid", res_valid, m_valid);
        check_eq("res_data", res_data, m_data);
        check_eq("res_id", res_id, m_id);
        check_eq("sat_count", sat_count, m_sat);
        for (int i = 0; i < N; i++) if (exp_ready[i]) lv[i] = 1'b0;
    endtask

    task automatic one_lane0(input logic [WP-1:0] p);
        lp[0] = p;
        lv[0] = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin lv[i] = 1'b0; lp[i] = '0; end
        rst = 1'b1; res_ready = 1'b1;
        req_valid = '0; req_prod = '0;
        m_valid = 1'b0; m_data = 0; m_id = 0; m_rr = 0; m_sat = 0;
        tick();
        tick();
        check_eq("rst_valid", res_valid, 1'b0);
        check_eq("rst_data", res_data, 0);
        rst = 1'b0;

        one_lane0(8'h14);
        check_eq("rnd_14", res_data, 4'h3);
        check_eq("rnd_14_id", res_id, 0);
        one_lane0(8'hE4);
        check_eq("rnd_E4", res_data, 4'hD);
        one_lane0(8'h3C);
`ifdef ROUND_SAT_EN
        check_eq("rnd_3C", res_data, 4'h7);
        check_eq("sat_3C", sat_count, 1);
`else
        check_eq("rnd_3C", res_data, 4'h8);
        check_eq("sat_3C", sat_count, 0);
`endif
        one_lane0(8'hC0);
`ifdef ROUND_SAT_EN
        check_eq("rnd_C0", res_data, 4'h9);
        check_eq("sat_C0", sat_count, 2);
`else
        check_eq("rnd_C0", res_data, 4'h8);
        check_eq("sat_C0", sat_count, 0);
`endif
        tick();
        check_eq("drain_valid", res_valid, 1'b0);

        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) begin lv[i] = 1'b1; lp[i] = WP'($urandom); end
        for (int s = 0; s < 5; s++) begin
            tick();
            check_eq("rr_order", res_id, s % N);
            check_eq("rr_onehot", $countones(last_dut_ready), 1);
            check_eq("rr_valid", res_valid, 1'b1);
            for (int i = 0; i < N; i++) if (!lv[i]) begin lv[i] = 1'b1; lp[i] = WP'($urandom); end
        end

        for (int i = 0; i < N; i++) lv[i] = 1'b0;
        lv[1] = 1'b1; lv[2] = 1'b1;
        res_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_eq("bp_ready", last_dut_ready, 0);
            check_eq("bp_id", res_id, 0);
            check_eq("bp_valid", res_valid, 1'b1);
        end
        res_ready = 1'b1;
        tick();
        check_eq("bp_rel1", res_id, 1);
        tick();
        check_eq("bp_rel2", res_id, 2);
        check_eq("bp_nobubble", res_valid, 1'b1);

        for (int i = 0; i < N; i++) begin lv[i] = 1'b1; lp[i] = WP'($urandom); end
        res_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_eq("mid_rst_ready", last_dut_ready, 0);
        check_eq("mid_rst_valid", res_valid, 1'b0);
        check_eq("mid_rst_sat", sat_count, 0);
        rst = 1'b0; res_ready = 1'b1;
        tick();
        check_eq("post_rst_id", res_id, 0);

        for (int s = 0; s < 400; s++) begin
            rst       = ($urandom_range(0, 99) == 0);
            res_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++)
                if (!lv[i] && $urandom_range(0, 1) == 1) begin lv[i] = 1'b1; lp[i] = WP'($urandom); end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
